clk_div_multi: RTL and testbench

//  Multi-channel programmable clock divider and clock-enable generator, the

---
 rtl/clk_div_pkg.sv | 33 +++
 rtl/clk_div_ch.sv | 70 +++++++
 rtl/clk_div_multi.sv | 92 +++++++++
 tb/tb_clk_div_multi.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// ============================================================================
//  Package   : clk_div_pkg
//  Purpose   : Shared types, defaults and helpers for the clk_div_multi block
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

   localparam int C_LOCK_CYCLES_DEF = 16;

   typedef enum logic [0:0] {
      ST_SETTLE = 1'b0,
      ST_LOCKED = 1'b1
   } settle_state_t;

   function automatic int ch_width(input int num_ch);
      return (num_ch <= 2) ? 1 : $clog2(num_ch);
   endfunction

   // Power-up divide for channel idx is 2<<idx, clipped to the largest ratio
   // the divide field can hold.
   function automatic logic [31:0] default_div(input int idx, input int div_w);
      logic [63:0] v;
      logic [63:0] vmax;
      v    = 64'd2 << idx;
      vmax = (64'd1 << div_w) - 64'd1;
      return (v > vmax) ? vmax[31:0] : v[31:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/clk_div_ch.sv
// ============================================================================
//  Module    : clk_div_ch
//  Purpose   : One divider channel: shadow/active config, counter, output flops
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_ch #(
   parameter int               DIV_W   = 8,
   parameter logic [DIV_W-1:0] DEF_DIV = 2
) (
   input  logic             clk,
   input  logic             sys_rst,
   input  logic             wr_en,
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DIV_W-1:0] wr_phase,
   input  logic             apply,
   output logic             clk_out,
   output logic             ce_out
);

   logic [DIV_W-1:0] r_sh_div;
   logic [DIV_W-1:0] r_sh_phase;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic             r_clk_out;
   logic             r_ce_out;

   logic [DIV_W-1:0] w_sh_div;
   logic [DIV_W-1:0] w_sh_phase;
   logic [DIV_W-1:0] w_div_next;
   logic [DIV_W-1:0] w_cnt_next;

   // A write in the apply cycle is forwarded so the commit already includes it.
   always_comb begin
      w_sh_div   = wr_en ? wr_div : r_sh_div;
      w_sh_phase = wr_en ? wr_phase : r_sh_phase;
      if (apply) begin
         w_div_next = w_sh_div;
         w_cnt_next = w_sh_phase;
      end else begin
         w_div_next = r_div;
         w_cnt_next = (r_cnt == r_div - DIV_W'(1)) ? '0 : r_cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_sh_div   <= DEF_DIV;
         r_sh_phase <= '0;
         r_div      <= DEF_DIV;
         r_cnt      <= '0;
         r_clk_out  <= 1'b0;
         r_ce_out   <= 1'b0;
      end else begin
         r_sh_div   <= w_sh_div;
         r_sh_phase <= w_sh_phase;
         r_div      <= w_div_next;
         r_cnt      <= w_cnt_next;
         r_clk_out  <= (w_cnt_next < (w_div_next >> 1));
         r_ce_out   <= (w_cnt_next == w_div_next - DIV_W'(1));
      end
   end

   assign clk_out = r_clk_out;
   assign ce_out  = r_ce_out;

endmodule

`default_nettype wire

// File: rtl/clk_div_multi.sv
// ============================================================================
//  Module    : clk_div_multi
//  Purpose   : Multi-channel programmable clock divider / enable generator
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int DIV_W       = 8,
   parameter  int LOCK_CYCLES = C_LOCK_CYCLES_DEF,
   localparam int CH_W        = ch_width(NUM_CH)
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   input  logic              cfg_apply,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] ce_out,
   output logic              locked
);

   localparam int CNT_W = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES);

   settle_state_t    r_state;
   logic [CNT_W-1:0] r_settle_cnt;
   logic             r_locked;
   logic             r_cfg_err;
   logic             w_bad;
   logic             w_wr_ok;

   // One extra bit on the channel index so NUM_CH itself is representable.
   assign w_bad   = (cfg_div < DIV_W'(2)) || (cfg_phase >= cfg_div) ||
                    ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));
   assign w_wr_ok = cfg_we && !w_bad;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_div_ch #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DIV_W'(default_div(g, DIV_W)))
      ) u_ch (
         .clk      (clk),
         .sys_rst  (sys_rst),
         .wr_en    (w_wr_ok && (cfg_ch == CH_W'(g))),
         .wr_div   (cfg_div),
         .wr_phase (cfg_phase),
         .apply    (cfg_apply),
         .clk_out  (clk_out[g]),
         .ce_out   (ce_out[g])
      );
   end

   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_state      <= ST_SETTLE;
         r_settle_cnt <= '0;
         r_locked     <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_cfg_err <= cfg_we && w_bad;
         if (cfg_apply) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_locked     <= 1'b0;
         end else begin
            case (r_state)
               ST_SETTLE: begin
                  if (r_settle_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                     r_state  <= ST_LOCKED;
                     r_locked <= 1'b1;
                  end else begin
                     r_settle_cnt <= r_settle_cnt + CNT_W'(1);
                  end
               end
               ST_LOCKED: r_locked <= 1'b1;
            endcase
         end
      end
   end

   assign cfg_err = r_cfg_err;
   assign locked  = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
//  Module    : tb_clk_div_multi
//  Purpose   : Directed self-checking bench for clk_div_multi
//  Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

   logic       clk       = 1'b0;
   logic       sys_rst   = 1'b0;
   logic       cfg_we    = 1'b0;
   logic       cfg_apply = 1'b0;
   logic [1:0] cfg_ch    = '0;
   logic [7:0] cfg_div   = '0;
   logic [7:0] cfg_phase = '0;
   logic       cfg_err;
   logic       locked;
   logic [3:0] clk_out;
   logic [3:0] ce_out;

   // Second instance with a non-power-of-two channel count for index checks.
   logic       cfg_we3    = 1'b0;
   logic [1:0] cfg_ch3    = '0;
   logic [7:0] cfg_div3   = '0;
   logic [7:0] cfg_phase3 = '0;
   logic       cfg_err3;
   logic       locked3;
   logic [2:0] clk_out3;
   logic [2:0] ce_out3;

   int errors = 0;
   int checks = 0;
   int m_div[4];
   int m_ph[4];

   always #5 clk = ~clk;

   clk_div_multi #(.NUM_CH(4), .DIV_W(8), .LOCK_CYCLES(16)) u_dut (
      .clk       (clk),
      .sys_rst   (sys_rst),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_apply (cfg_apply),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .ce_out    (ce_out),
      .locked    (locked)
   );

   clk_div_multi #(.NUM_CH(3), .DIV_W(8), .LOCK_CYCLES(16)) u_dut3 (
      .clk       (clk),
      .sys_rst   (sys_rst),
      .cfg_we    (cfg_we3),
      .cfg_ch    (cfg_ch3),
      .cfg_div   (cfg_div3),
      .cfg_phase (cfg_phase3),
      .cfg_apply (1'b0),
      .cfg_err   (cfg_err3),
      .clk_out   (clk_out3),
      .ce_out    (ce_out3),
      .locked    (locked3)
   );

   // Expected outputs j edges after a counter (re)start at phase m_ph.
   function automatic logic [3:0] exp_clk(input int j);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (((m_ph[i] + j) % m_div[i]) < (m_div[i] / 2));
      return r;
   endfunction

   function automatic logic [3:0] exp_ce(input int j);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (((m_ph[i] + j) % m_div[i]) == (m_div[i] - 1));
      return r;
   endfunction

   task automatic test_reset();
      logic exp_lk;
      sys_rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (clk_out !== 4'b0 || ce_out !== 4'b0) begin
         errors++;
         $display("FAIL reset_outputs clk_out=%b ce_out=%b expected 0000/0000", clk_out, ce_out);
      end
      checks++;
      if (locked !== 1'b0 || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags locked=%b cfg_err=%b expected 0/0", locked, cfg_err);
      end
      m_div = '{2, 4, 8, 16};
      m_ph  = '{0, 0, 0, 0};
      sys_rst = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_lk = (k == 16);
         checks++;
         if (clk_out !== exp_clk(k)) begin
            errors++;
            $display("FAIL reset_clk k=%0d got=%b exp=%b", k, clk_out, exp_clk(k));
         end
         checks++;
         if (ce_out !== exp_ce(k)) begin
            errors++;
            $display("FAIL reset_ce k=%0d got=%b exp=%b", k, ce_out, exp_ce(k));
         end
         checks++;
         if (locked !== exp_lk) begin
            errors++;
            $display("FAIL reset_locked k=%0d got=%b exp=%b", k, locked, exp_lk);
         end
      end
   endtask

   task automatic test_div5();
      logic exp_lk;
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5; cfg_phase = 8'd0;
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (clk_out !== exp_clk(17) || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL div5_shadow_only clk_out=%b err=%b exp=%b/0", clk_out, cfg_err, exp_clk(17));
      end
      m_div[1] = 5;
      cfg_apply = 1'b1;
      for (int j = 0; j <= 16; j++) begin
         @(negedge clk);
         if (j == 0) cfg_apply = 1'b0;
         exp_lk = (j == 16);
         checks++;
         if (clk_out !== exp_clk(j)) begin
            errors++;
            $display("FAIL div5_clk j=%0d got=%b exp=%b", j, clk_out, exp_clk(j));
         end
         checks++;
         if (ce_out !== exp_ce(j)) begin
            errors++;
            $display("FAIL div5_ce j=%0d got=%b exp=%b", j, ce_out, exp_ce(j));
         end
         checks++;
         if (locked !== exp_lk) begin
            errors++;
            $display("FAIL div5_locked j=%0d got=%b exp=%b", j, locked, exp_lk);
         end
      end
   endtask

   task automatic test_phase();
      logic exp_lk;
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd4; cfg_phase = 8'd2;
      @(negedge clk);
      cfg_ch = 2'd3; cfg_phase = 8'd0;
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL phase_write_err got=%b exp=0", cfg_err);
      end
      m_div = '{2, 5, 4, 4};
      m_ph  = '{0, 0, 2, 0};
      cfg_apply = 1'b1;
      for (int j = 0; j <= 16; j++) begin
         @(negedge clk);
         if (j == 0) cfg_apply = 1'b0;
         exp_lk = (j == 16);
         checks++;
         if (clk_out !== exp_clk(j) || clk_out[2] !== ~clk_out[3]) begin
            errors++;
            $display("FAIL phase_clk j=%0d got=%b exp=%b", j, clk_out, exp_clk(j));
         end
         checks++;
         if (ce_out !== exp_ce(j)) begin
            errors++;
            $display("FAIL phase_ce j=%0d got=%b exp=%b", j, ce_out, exp_ce(j));
         end
         checks++;
         if (locked !== exp_lk) begin
            errors++;
            $display("FAIL phase_locked j=%0d got=%b exp=%b", j, locked, exp_lk);
         end
      end
   endtask

   task automatic test_illegal();
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1; cfg_phase = 8'd0;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_div1 cfg_err=%b exp=1", cfg_err);
      end
      cfg_ch = 2'd1; cfg_div = 8'd6; cfg_phase = 8'd6;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_phase cfg_err=%b exp=1", cfg_err);
      end
      cfg_we = 1'b0;
      cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd4; cfg_phase3 = 8'd0;
      @(negedge clk);
      checks++;
      if (cfg_err3 !== 1'b1 || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_ch err3=%b err=%b exp=1/0", cfg_err3, cfg_err);
      end
      cfg_ch3 = 2'd2;
      @(negedge clk);
      cfg_we3 = 1'b0;
      checks++;
      if (cfg_err3 !== 1'b0) begin
         errors++;
         $display("FAIL legal_ch err3=%b exp=0", cfg_err3);
      end
      cfg_apply = 1'b1;
      for (int j = 0; j <= 12; j++) begin
         @(negedge clk);
         if (j == 0) cfg_apply = 1'b0;
         checks++;
         if (clk_out !== exp_clk(j) || ce_out !== exp_ce(j)) begin
            errors++;
            $display("FAIL illegal_unchanged j=%0d clk=%b ce=%b exp=%b/%b", j, clk_out, ce_out, exp_clk(j), exp_ce(j));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_lk;
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6; cfg_phase = 8'd0;
      cfg_apply = 1'b1;
      m_div[0] = 6;
      for (int j = 0; j <= 10; j++) begin
         @(negedge clk);
         if (j == 0) begin
            cfg_we = 1'b0;
            cfg_apply = 1'b0;
         end
         checks++;
         if (clk_out !== exp_clk(j) || ce_out !== exp_ce(j) || locked !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle j=%0d clk=%b ce=%b lk=%b exp=%b/%b/0", j, clk_out, ce_out, locked, exp_clk(j), exp_ce(j));
         end
      end
      cfg_apply = 1'b1;
      for (int j = 0; j <= 16; j++) begin
         @(negedge clk);
         if (j == 0) cfg_apply = 1'b0;
         exp_lk = (j == 16);
         checks++;
         if (clk_out !== exp_clk(j) || ce_out !== exp_ce(j)) begin
            errors++;
            $display("FAIL reapply_out j=%0d clk=%b ce=%b exp=%b/%b", j, clk_out, ce_out, exp_clk(j), exp_ce(j));
         end
         checks++;
         if (locked !== exp_lk) begin
            errors++;
            $display("FAIL reapply_locked j=%0d got=%b exp=%b", j, locked, exp_lk);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic exp_lk;
      #2;
      sys_rst = 1'b0;
      #1;
      checks++;
      if (clk_out !== 4'b0 || ce_out !== 4'b0 || locked !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async clk=%b ce=%b lk=%b exp=0000/0000/0", clk_out, ce_out, locked);
      end
      @(negedge clk);
      sys_rst = 1'b1;
      m_div = '{2, 4, 8, 16};
      m_ph  = '{0, 0, 0, 0};
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_lk = (k == 16);
         checks++;
         if (clk_out !== exp_clk(k) || ce_out !== exp_ce(k) || locked !== exp_lk) begin
            errors++;
            $display("FAIL midreset_resume k=%0d clk=%b ce=%b lk=%b exp=%b/%b/%b", k, clk_out, ce_out, locked, exp_clk(k), exp_ce(k), exp_lk);
         end
      end
      cfg_apply = 1'b1;
      for (int j = 0; j <= 7; j++) begin
         @(negedge clk);
         if (j == 0) cfg_apply = 1'b0;
         checks++;
         if (clk_out !== exp_clk(j) || ce_out !== exp_ce(j)) begin
            errors++;
            $display("FAIL midreset_shadow j=%0d clk=%b ce=%b exp=%b/%b", j, clk_out, ce_out, exp_clk(j), exp_ce(j));
         end
      end
   endtask

   initial begin
      test_reset();
      test_div5();
      test_phase();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
